// File: rtl/cordic_pkg.sv
// cordic_pkg: CORDIC arctangent table (degrees) and gain-compensation shift constants
package cordic_pkg;
  localparam int MAX_STAGES = 16;
  localparam int ATAN_DEG [MAX_STAGES] = '{45, 27, 14, 7, 4, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int GC_TERMS = 4;
  localparam int GC_SHIFT [GC_TERMS] = '{1, 3, 6, 9};
  localparam bit GC_NEG [GC_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1};
  function automatic int atan(input int k);
    return ATAN_DEG[k];
  endfunction
endpackage

// File: rtl/cordic_vec_pipe_if.sv
// cordic_vec_pipe_if: valid/ready beat bus carrying vectors, residual angle, enable and sideband
interface cordic_vec_pipe_if #(parameter int DATA_W = 19, ANG_W = 9, NUM_VEC = 4, SIDE_W = 48);
  logic valid;
  logic ready;
  logic en;
  logic [SIDE_W-1:0] side;
  logic [NUM_VEC*DATA_W-1:0] vx;
  logic [NUM_VEC*DATA_W-1:0] vy;
  logic [ANG_W-1:0] z;
  modport master(output valid, en, side, vx, vy, z, input ready);
  modport slave(input valid, en, side, vx, vy, z, output ready);
endinterface

// File: rtl/cordic_step.sv
// cordic_step: one registered CORDIC micro-rotation by 2^-SHIFT over NUM_VEC lanes sharing one direction
module cordic_step
  import cordic_pkg::*;
#(parameter int DATA_W = 19, ANG_W = 9, NUM_VEC = 4, SIDE_W = 48, SHIFT = 0)(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic valid,
  input  logic en,
  input  logic [SIDE_W-1:0] side,
  input  logic [NUM_VEC*DATA_W-1:0] vx,
  input  logic [NUM_VEC*DATA_W-1:0] vy,
  input  logic [ANG_W-1:0] z,
  output logic valid_q,
  output logic en_q,
  output logic [SIDE_W-1:0] side_q,
  output logic [NUM_VEC*DATA_W-1:0] vx_q,
  output logic [NUM_VEC*DATA_W-1:0] vy_q,
  output logic [ANG_W-1:0] z_q
);
  localparam logic [ANG_W-1:0] ATAN = ANG_W'(atan(SHIFT));
  logic neg;
  logic [NUM_VEC*DATA_W-1:0] rx, ry;
  logic [ANG_W-1:0] rz;
  assign neg = z[ANG_W-1];
  assign rz = !en ? z : neg ? z + ATAN : z - ATAN;
  for (genvar i = 0; i < NUM_VEC; i++) begin : g_lane
    logic signed [DATA_W-1:0] x, y;
    assign x = vx[i*DATA_W +: DATA_W];
    assign y = vy[i*DATA_W +: DATA_W];
    assign rx[i*DATA_W +: DATA_W] = !en ? x : neg ? x + (y >>> SHIFT) : x - (y >>> SHIFT);
    assign ry[i*DATA_W +: DATA_W] = !en ? y : neg ? y - (x >>> SHIFT) : y + (x >>> SHIFT);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) valid_q <= 1'b0;
    else if (!hold) valid_q <= valid;
  // payload is deliberately unreset; bubbles carry don't-care data
  always_ff @(posedge clk)
    if (!hold) {side_q, en_q, vx_q, vy_q, z_q} <= {side, en, rx, ry, rz};
endmodule

// File: rtl/cordic_vec_pipe.sv
// cordic_vec_pipe: STAGES-deep global-stall CORDIC rotator; CORDIC_GAIN_COMP_EN appends a 0.60742 gain stage
module cordic_vec_pipe
  import cordic_pkg::*;
#(parameter int DATA_W = 19, ANG_W = 9, NUM_VEC = 4, STAGES = 8, SIDE_W = 48)(
  input logic clk,
  input logic reset,
  cordic_vec_pipe_if.slave in_bus,
  cordic_vec_pipe_if.master out_bus
);
  localparam int VW = NUM_VEC * DATA_W;
  logic adv;
  logic v [STAGES+1];
  logic e [STAGES+1];
  logic [SIDE_W-1:0] s [STAGES+1];
  logic [VW-1:0] x [STAGES+1];
  logic [VW-1:0] y [STAGES+1];
  logic [ANG_W-1:0] z [STAGES+1];
  assign adv = !out_bus.valid || out_bus.ready;
  assign in_bus.ready = adv;
  assign v[0] = in_bus.valid;
  assign e[0] = in_bus.en;
  assign s[0] = in_bus.side;
  assign x[0] = in_bus.vx;
  assign y[0] = in_bus.vy;
  assign z[0] = in_bus.z;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cordic_step #(.DATA_W(DATA_W), .ANG_W(ANG_W), .NUM_VEC(NUM_VEC), .SIDE_W(SIDE_W), .SHIFT(k)) u_step (
      .clk(clk), .reset(reset), .hold(!adv),
      .valid(v[k]), .en(e[k]), .side(s[k]), .vx(x[k]), .vy(y[k]), .z(z[k]),
      .valid_q(v[k+1]), .en_q(e[k+1]), .side_q(s[k+1]), .vx_q(x[k+1]), .vy_q(y[k+1]), .z_q(z[k+1]));
  end
`ifdef CORDIC_GAIN_COMP_EN
  logic cv, ce;
  logic [SIDE_W-1:0] cs;
  logic [VW-1:0] cx, cy, gx, gy;
  logic [ANG_W-1:0] cz;
  for (genvar i = 0; i < NUM_VEC; i++) begin : g_comp
    logic signed [DATA_W-1:0] a, b;
    logic signed [DATA_W-1:0] ta [GC_TERMS];
    logic signed [DATA_W-1:0] tb [GC_TERMS];
    assign a = x[STAGES][i*DATA_W +: DATA_W];
    assign b = y[STAGES][i*DATA_W +: DATA_W];
    for (genvar j = 0; j < GC_TERMS; j++) begin : g_term
      assign ta[j] = GC_NEG[j] ? -(a >>> GC_SHIFT[j]) : a >>> GC_SHIFT[j];
      assign tb[j] = GC_NEG[j] ? -(b >>> GC_SHIFT[j]) : b >>> GC_SHIFT[j];
    end
    assign gx[i*DATA_W +: DATA_W] = ta[0] + ta[1] + ta[2] + ta[3];
    assign gy[i*DATA_W +: DATA_W] = tb[0] + tb[1] + tb[2] + tb[3];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cv <= 1'b0;
    else if (adv) cv <= v[STAGES];
  always_ff @(posedge clk)
    if (adv) {cs, ce, cx, cy, cz} <= {s[STAGES], e[STAGES], e[STAGES] ? gx : x[STAGES], e[STAGES] ? gy : y[STAGES], z[STAGES]};
  assign out_bus.valid = cv;
  assign out_bus.en = ce;
  assign out_bus.side = cs;
  assign out_bus.vx = cx;
  assign out_bus.vy = cy;
  assign out_bus.z = cz;
`else
  assign out_bus.valid = v[STAGES];
  assign out_bus.en = e[STAGES];
  assign out_bus.side = s[STAGES];
  assign out_bus.vx = x[STAGES];
  assign out_bus.vy = y[STAGES];
  assign out_bus.z = z[STAGES];
`endif
endmodule

// File: tb/tb_cordic_vec_pipe.sv
// tb_cordic_vec_pipe: randomized and directed checks of cordic_vec_pipe against an integer CORDIC model
module tb_cordic_vec_pipe;
  localparam int DATA_W = 19, ANG_W = 9, NUM_VEC = 4, STAGES = 8, SIDE_W = 48, VW = NUM_VEC * DATA_W;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = STAGES + 1;
`else
  localparam int LAT = STAGES;
`endif
  localparam int AT [16] = '{45, 27, 14, 7, 4, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  typedef struct packed {
    logic [SIDE_W-1:0] side;
    logic [VW-1:0] vx;
    logic [VW-1:0] vy;
    logic [ANG_W-1:0] z;
    logic en;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  beat_t q [$];
  cordic_vec_pipe_if #(.DATA_W(DATA_W), .ANG_W(ANG_W), .NUM_VEC(NUM_VEC), .SIDE_W(SIDE_W)) in_if ();
  cordic_vec_pipe_if #(.DATA_W(DATA_W), .ANG_W(ANG_W), .NUM_VEC(NUM_VEC), .SIDE_W(SIDE_W)) out_if ();
  cordic_vec_pipe #(.DATA_W(DATA_W), .ANG_W(ANG_W), .NUM_VEC(NUM_VEC), .STAGES(STAGES), .SIDE_W(SIDE_W)) dut (
    .clk(clk), .reset(reset), .in_bus(in_if), .out_bus(out_if));
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction
  function automatic int wd(input int a);
    logic [DATA_W-1:0] t;
    t = a[DATA_W-1:0];
    return sx(t);
  endfunction
  function automatic int wz(input int a);
    logic [ANG_W-1:0] t;
    t = a[ANG_W-1:0];
    return int'($signed(t));
  endfunction
  function automatic int comp(input int v);
    return wd((v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9));
  endfunction
  function automatic beat_t model(input beat_t b);
    beat_t r;
    int x [NUM_VEC];
    int y [NUM_VEC];
    int zz, nx;
    bit neg;
    r = b;
    if (b.en) begin
      zz = wz(int'(b.z));
      for (int i = 0; i < NUM_VEC; i++) begin
        x[i] = sx(b.vx[i*DATA_W +: DATA_W]);
        y[i] = sx(b.vy[i*DATA_W +: DATA_W]);
      end
      for (int k = 0; k < STAGES; k++) begin
        neg = zz < 0;
        for (int i = 0; i < NUM_VEC; i++) begin
          nx = neg ? x[i] + (y[i] >>> k) : x[i] - (y[i] >>> k);
          y[i] = wd(neg ? y[i] - (x[i] >>> k) : y[i] + (x[i] >>> k));
          x[i] = wd(nx);
        end
        zz = wz(neg ? zz + AT[k] : zz - AT[k]);
      end
      for (int i = 0; i < NUM_VEC; i++) begin
`ifdef CORDIC_GAIN_COMP_EN
        x[i] = comp(x[i]);
        y[i] = comp(y[i]);
`endif
        r.vx[i*DATA_W +: DATA_W] = x[i][DATA_W-1:0];
        r.vy[i*DATA_W +: DATA_W] = y[i][DATA_W-1:0];
      end
      r.z = zz[ANG_W-1:0];
    end
    return r;
  endfunction

  beat_t pv;
  bit stall_p = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = {out_if.side, out_if.vx, out_if.vy, out_if.z, out_if.en};
    if (!reset) begin
      q.delete();
      stall_p = 1'b0;
    end else begin
      chk(in_if.ready === (!out_if.valid || out_if.ready), "in_ready", in_if.ready, !out_if.valid || out_if.ready);
      if (stall_p) chk(out_if.valid === 1'b1 && cur === pv, "stall_stable", cur, pv);
      if (out_if.valid && out_if.ready) begin
        if (q.size() == 0) chk(1'b0, "extra_beat", cur, 0);
        else begin
          e = q.pop_front();
          chk(cur === e, "out_beat", cur, e);
        end
      end
      if (in_if.valid && in_if.ready) q.push_back(model({in_if.side, in_if.vx, in_if.vy, in_if.z, in_if.en}));
      stall_p = out_if.valid && !out_if.ready;
      pv = cur;
    end
  end

  function automatic logic [VW-1:0] rv();
    return VW'({$urandom(), $urandom(), $urandom()});
  endfunction
  function automatic logic [SIDE_W-1:0] rs();
    return SIDE_W'({$urandom(), $urandom()});
  endfunction
  task automatic put(input bit v, input logic [SIDE_W-1:0] s, input logic [VW-1:0] x, input logic [VW-1:0] y,
                     input logic [ANG_W-1:0] z, input bit en);
    in_if.valid = v;
    in_if.side = s;
    in_if.vx = x;
    in_if.vy = y;
    in_if.z = z;
    in_if.en = en;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic lat_wait(output int n);
    cyc();
    in_if.valid = 1'b0;
    n = 1;
    while (!out_if.valid && n < 64) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    beat_t b, m;
    logic [VW-1:0] tx, ty;
    logic [SIDE_W-1:0] mark;
    int n, first, cnt, last;
    put(1'b0, '0, '0, '0, '0, 1'b0);
    out_if.ready = 1'b0;
    b = '0;
    b.en = 1'b1;
    b.vx[DATA_W-1:0] = 19'd256;
    b.z = 9'd90;
    m = model(b);
`ifdef CORDIC_GAIN_COMP_EN
    chk(sx(m.vx[DATA_W-1:0]) == -1 && sx(m.vy[DATA_W-1:0]) == 257 && m.z == 9'd0, "model_rot", m, 0);
`else
    chk(sx(m.vx[DATA_W-1:0]) == -4 && sx(m.vy[DATA_W-1:0]) == 422 && m.z == 9'd0, "model_rot", m, 0);
`endif
    b.vx[DATA_W-1:0] = 19'h3FFFF;
    b.vy[DATA_W-1:0] = 19'h3FFFF;
    b.z = 9'd45;
    m = model(b);
`ifdef CORDIC_GAIN_COMP_EN
    chk(sx(m.vx[DATA_W-1:0]) == -1 && sx(m.vy[DATA_W-1:0]) == 0 && m.z == 9'h1FF, "model_wrap", m, 0);
`else
    chk(sx(m.vx[DATA_W-1:0]) == -4 && sx(m.vy[DATA_W-1:0]) == 0 && m.z == 9'h1FF, "model_wrap", m, 0);
`endif
    b.en = 1'b0;
    chk(model(b) === b, "model_pass", model(b), b);
    cyc();
    cyc();
    chk(out_if.valid === 1'b0, "reset_out_valid", out_if.valid, 0);
    chk(in_if.ready === 1'b1, "reset_in_ready", in_if.ready, 1);
    #2 reset = 1'b1;
    out_if.ready = 1'b1;
    cyc();
    tx = rv();
    ty = rv();
    tx[DATA_W-1:0] = 19'd1000;
    ty[DATA_W-1:0] = 19'h7FE0C;
    put(1'b1, rs(), tx, ty, 9'd30, 1'b0);
    lat_wait(n);
    chk(n == LAT, "pass_latency", n, LAT);
    chk(out_if.vx === tx && out_if.vy === ty, "pass_vec", {out_if.vx, out_if.vy}, {tx, ty});
    chk(out_if.z === 9'd30 && out_if.en === 1'b0, "pass_z", out_if.z, 30);
    tx = rv();
    ty = rv();
    tx[DATA_W-1:0] = 19'd256;
    ty[DATA_W-1:0] = 19'd0;
    put(1'b1, rs(), tx, ty, 9'd90, 1'b1);
    lat_wait(n);
    chk(n == LAT, "rot_latency", n, LAT);
    chk(sx(out_if.vx[DATA_W-1:0]) >= -4 && sx(out_if.vx[DATA_W-1:0]) <= 4, "rot_x_range", out_if.vx[DATA_W-1:0], 0);
`ifdef CORDIC_GAIN_COMP_EN
    chk(sx(out_if.vy[DATA_W-1:0]) >= 252 && sx(out_if.vy[DATA_W-1:0]) <= 260, "rot_y_range", out_if.vy[DATA_W-1:0], 256);
    chk(sx(out_if.vx[DATA_W-1:0]) == -1 && sx(out_if.vy[DATA_W-1:0]) == 257, "rot_exact", out_if.vy[DATA_W-1:0], 257);
`else
    chk(sx(out_if.vy[DATA_W-1:0]) >= 417 && sx(out_if.vy[DATA_W-1:0]) <= 425, "rot_y_range", out_if.vy[DATA_W-1:0], 421);
    chk(sx(out_if.vx[DATA_W-1:0]) == -4 && sx(out_if.vy[DATA_W-1:0]) == 422, "rot_exact", out_if.vy[DATA_W-1:0], 422);
`endif
    tx = rv();
    tx[DATA_W-1:0] = 19'h3FFFF;
    ty = rv();
    ty[DATA_W-1:0] = 19'h3FFFF;
    put(1'b1, rs(), tx, ty, 9'd45, 1'b1);
    lat_wait(n);
`ifdef CORDIC_GAIN_COMP_EN
    chk(sx(out_if.vx[DATA_W-1:0]) == -1 && sx(out_if.vy[DATA_W-1:0]) == 0 && out_if.z == 9'h1FF, "wrap_exact", out_if.vx[DATA_W-1:0], 19'h7FFFF);
`else
    chk(sx(out_if.vx[DATA_W-1:0]) == -4 && sx(out_if.vy[DATA_W-1:0]) == 0 && out_if.z == 9'h1FF, "wrap_exact", out_if.vx[DATA_W-1:0], 19'h7FFFC);
`endif
    cyc();
    first = 0;
    cnt = 0;
    last = 0;
    for (int c = 1; c <= 100 + LAT + 5; c++) begin
      if (c <= 100) put(1'b1, rs(), rv(), rv(), ANG_W'($urandom()), 1'($urandom()));
      else in_if.valid = 1'b0;
      cyc();
      if (out_if.valid) begin
        if (first == 0) first = c;
        cnt++;
        last = c;
      end
    end
    chk(first == LAT, "tput_first", first, LAT);
    chk(cnt == 100 && last - first + 1 == 100, "tput_count", cnt, 100);
    for (int c = 0; c < LAT + 4; c++) begin
      put(1'b1, rs(), rv(), rv(), ANG_W'($urandom()), 1'($urandom()));
      cyc();
    end
    out_if.ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      put(1'b1, rs(), rv(), rv(), ANG_W'($urandom()), 1'($urandom()));
      cyc();
      chk(in_if.ready === 1'b0 && out_if.valid === 1'b1, "bp_full", {in_if.ready, out_if.valid}, 2'b01);
    end
    out_if.ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      put($urandom_range(3) != 0, rs(), rv(), rv(), ANG_W'($urandom()), 1'($urandom()));
      out_if.ready = $urandom_range(3) != 0;
      cyc();
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 64) begin
      cyc();
      n++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
    cyc();
    out_if.ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      put(1'b1, rs(), rv(), rv(), ANG_W'($urandom()), 1'b1);
      cyc();
    end
    in_if.valid = 1'b0;
    n = 0;
    while (!out_if.valid && n < 64) begin
      cyc();
      n++;
    end
    chk(out_if.valid === 1'b1, "rst_pre", out_if.valid, 1);
    #2 reset = 1'b0;
    #1;
    chk(out_if.valid === 1'b0, "rst_async_valid", out_if.valid, 0);
    chk(in_if.ready === 1'b1, "rst_async_ready", in_if.ready, 1);
    cyc();
    cyc();
    #2 reset = 1'b1;
    out_if.ready = 1'b1;
    mark = 48'hA5A5_0000_1234;
    put(1'b1, mark, rv(), rv(), ANG_W'($urandom()), 1'b1);
    lat_wait(n);
    chk(n == LAT, "rst_after_latency", n, LAT);
    chk(out_if.side === mark, "rst_first_beat", out_if.side, mark);
    cyc();
    cyc();
    chk(q.size() == 0, "rst_no_stale", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d failed", n_fail, n_chk);
    $fatal(1);
  end
endmodule
